// File: rtl/lfsr_pkg.sv
// Shared types and constants for the LFSR command generator.
// Holds the FSM state enum, reference tap pairs and an all-ones helper.
package lfsr_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    BURST  = 2'd2
  } state_t;

  // Widest LFSR the all_ones helper can describe.
  localparam int MAX_W = 256;

  localparam int TAP52_A = 51;
  localparam int TAP52_B = 48;
  localparam int TAP32_A = 31;
  localparam int TAP32_B = 21;
  localparam int TAP16_A = 15;
  localparam int TAP16_B = 13;

  function automatic logic [MAX_W-1:0] all_ones(input int w);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < w) r[i] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// Fibonacci XNOR LFSR register with guarded seed load and step enable.
// An all-ones seed would lock the XNOR LFSR, so it is replaced by SEED and flagged.
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 52,
  parameter int               TAP_A = 51,
  parameter int               TAP_B = 48,
  parameter logic [WIDTH-1:0] SEED  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             step,
  output logic [WIDTH-1:0] state,
  output logic             lockup
);

  localparam logic [WIDTH-1:0] ONES = WIDTH'(all_ones(WIDTH));

  generate
    if (WIDTH < 3) begin : g_bad_width
      $error("lfsr_core: WIDTH must be >= 3");
    end
    if (TAP_A >= WIDTH || TAP_B >= WIDTH) begin : g_bad_tap_range
      $error("lfsr_core: taps must be below WIDTH");
    end
    if (TAP_A == TAP_B) begin : g_bad_tap_equal
      $error("lfsr_core: TAP_A and TAP_B must differ");
    end
    if (SEED == ONES) begin : g_bad_seed
      $error("lfsr_core: SEED must not be all-ones");
    end
  endgenerate

  logic [WIDTH-1:0] state_reg;
  logic [WIDTH-1:0] lfsr_next;
  logic             lockup_reg;

  assign lfsr_next = {state_reg[WIDTH-2:0], ~(state_reg[TAP_A] ^ state_reg[TAP_B])};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= SEED;
      lockup_reg <= 1'b0;
    end else if (load) begin
      if (load_val == ONES) begin
        state_reg  <= SEED;
        lockup_reg <= 1'b1;
      end else begin
        state_reg  <= load_val;
        lockup_reg <= 1'b0;
      end
    end else if (step) begin
      state_reg <= lfsr_next;
    end
  end

  assign state  = state_reg;
  assign lockup = lockup_reg;

endmodule

// File: rtl/lfsr_cmd_gen.sv
// Pseudo-random command generator: LFSR words on a valid/ready stream,
// with stream and fixed-length burst modes, a done pulse and an accept counter.
module lfsr_cmd_gen
  import lfsr_pkg::*;
#(
  parameter int               WIDTH   = 52,
  parameter int               TAP_A   = TAP52_A,
  parameter int               TAP_B   = TAP52_B,
  parameter logic [WIDTH-1:0] SEED    = 1,
  parameter int               BURST_W = 16,
  parameter int               CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mode,
  input  logic               start,
  input  logic               stop,
  input  logic               seed_load,
  input  logic [WIDTH-1:0]   seed_in,
  input  logic [BURST_W-1:0] burst_len,
  output logic               cmd_valid,
  input  logic               cmd_ready,
  output logic [WIDTH-1:0]   cmd,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   cmd_count,
  output logic               lockup
);

  state_t             state_reg, state_next;
  logic [BURST_W-1:0] rem_reg, rem_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               done_reg, done_next;
  logic               hs;
  logic [CNT_W-1:0]   cnt_inc;

  assign cmd_valid = (state_reg != IDLE);
  assign hs        = cmd_valid && cmd_ready;
  // Saturate rather than wrap so a long stream never reports a small count.
  assign cnt_inc   = (cnt_reg == '1) ? cnt_reg : cnt_reg + CNT_W'(1);

  lfsr_core #(
    .WIDTH (WIDTH),
    .TAP_A (TAP_A),
    .TAP_B (TAP_B),
    .SEED  (SEED)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (seed_load && (state_reg == IDLE)),
    .load_val (seed_in),
    .step     (hs),
    .state    (cmd),
    .lockup   (lockup)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      rem_reg   <= '0;
      cnt_reg   <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      rem_reg   <= rem_next;
      cnt_reg   <= cnt_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    rem_next   = rem_reg;
    cnt_next   = cnt_reg;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          cnt_next = '0;
          if (!mode) begin
            state_next = STREAM;
          end else if (burst_len != '0) begin
            rem_next   = burst_len;
            state_next = BURST;
          end else begin
            done_next = 1'b1;
          end
        end
      end
      STREAM: begin
        if (hs) cnt_next = cnt_inc;
        if (stop) state_next = IDLE;
      end
      BURST: begin
        if (hs) begin
          cnt_next = cnt_inc;
          rem_next = rem_reg - BURST_W'(1);
          // Last word accepted: the burst completed even if stop arrives alongside.
          if (rem_reg == BURST_W'(1)) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end
        if (stop) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy      = (state_reg != IDLE);
  assign done      = done_reg;
  assign cmd_count = cnt_reg;

endmodule

// File: tb/tb_lfsr_cmd_gen.sv
// Randomised scoreboard bench for lfsr_cmd_gen: expected words are queued at
// start, a negedge monitor compares every offered word and count.
module tb_lfsr_cmd_gen;

  localparam int W  = 52;
  localparam int TA = 51;
  localparam int TB = 48;
  localparam int BW = 16;
  localparam int CW = 32;
  localparam logic [W-1:0] SEED_V = 52'h1;

  logic          clk;
  logic          rst;
  logic          mode;
  logic          start;
  logic          stop;
  logic          seed_load;
  logic [W-1:0]  seed_in;
  logic [BW-1:0] burst_len;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [W-1:0]  cmd;
  logic          busy;
  logic          done;
  logic [CW-1:0] cmd_count;
  logic          lockup;

  lfsr_cmd_gen #(
    .WIDTH   (W),
    .TAP_A   (TA),
    .TAP_B   (TB),
    .SEED    (SEED_V),
    .BURST_W (BW),
    .CNT_W   (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .start     (start),
    .stop      (stop),
    .seed_load (seed_load),
    .seed_in   (seed_in),
    .burst_len (burst_len),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd       (cmd),
    .busy      (busy),
    .done      (done),
    .cmd_count (cmd_count),
    .lockup    (lockup)
  );

  typedef struct {
    logic [W-1:0] word;
    int           cnt;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] model;
  int           n_checks = 0;
  int           n_fail   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference step: shift left by one, new bit 0 is 1 when the two tap bits agree.
  function automatic logic [W-1:0] model_next(input logic [W-1:0] x);
    logic fb;
    fb = (x[TA] == x[TB]);
    return (x << 1) | W'(fb);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every offered word must match the head of the queue; pop on accept.
  always @(negedge clk) begin
    if (!rst && cmd_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", {12'h0, cmd}, 64'hDEAD);
      end else begin
        chk("cmd_word", {12'h0, cmd}, {12'h0, exp_q[0].word});
        chk("cmd_count_live", {32'h0, cmd_count}, 64'(exp_q[0].cnt));
        if (cmd_ready) begin
          $display("accept word=0x%0h count=%0d", cmd, cmd_count);
          void'(exp_q.pop_front());
        end
      end
    end
    if (!rst && done) chk("done_without_busy", {63'h0, busy}, 64'h0);
  end

  // One run: n accepted words; stops early unless it is a burst of exactly n.
  // rmode: 0 random ready, 1 alternating from 1, 2 always ready.
  task automatic run_cmd(input bit m, input int len, input int n, input int rmode,
                         input bit do_seed, input logic [W-1:0] sv);
    int acc    = 0;
    int budget = 0;
    bit hs;
    bit natural;
    natural = m && (n == len);
    if (do_seed) model = sv;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{model, i});
      model = model_next(model);
    end
    $display("run mode=%0d len=%0d accepts=%0d seeded=%0d", m, len, n, do_seed);
    mode      = m;
    burst_len = BW'(len);
    seed_load = do_seed;
    seed_in   = sv;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    seed_load = 1'b0;
    chk("busy_after_start", {63'h0, busy}, 64'h1);
    while (acc < n && budget < 2000) begin
      case (rmode)
        0:       cmd_ready = 1'($urandom_range(0, 1));
        1:       cmd_ready = (budget % 2 == 0);
        default: cmd_ready = 1'b1;
      endcase
      hs   = cmd_valid && cmd_ready;
      stop = hs && (acc == n - 1) && !natural;
      tick();
      stop      = 1'b0;
      cmd_ready = 1'b0;
      if (hs) acc++;
      budget++;
    end
    if (acc < n) chk("run_timeout", 64'(acc), 64'(n));
    chk("valid_after_end", {63'h0, cmd_valid}, 64'h0);
    chk("busy_after_end", {63'h0, busy}, 64'h0);
    chk("done_after_end", {63'h0, done}, {63'h0, natural});
    chk("count_after_end", {32'h0, cmd_count}, 64'(n));
    chk("queue_drained", 64'(exp_q.size()), 64'h0);
    tick();
    chk("done_cleared", {63'h0, done}, 64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] sv;
    bit           m;
    int           len;
    int           n;

    rst = 1'b1; mode = 1'b0; start = 1'b0; stop = 1'b0; seed_load = 1'b0;
    seed_in = '0; burst_len = '0; cmd_ready = 1'b0;
    model = SEED_V;
    #2;
    chk("reset_cmd", {12'h0, cmd}, {12'h0, SEED_V});
    chk("reset_valid", {63'h0, cmd_valid}, 64'h0);
    chk("reset_busy", {63'h0, busy}, 64'h0);
    chk("reset_done", {63'h0, done}, 64'h0);
    chk("reset_count", {32'h0, cmd_count}, 64'h0);
    chk("reset_lockup", {63'h0, lockup}, 64'h0);
    tick();
    rst = 1'b0;
    tick();

    // Stream from SEED=1: words 1,3,7,F,1F leave the LFSR at 3F.
    run_cmd(1'b0, 0, 5, 2, 1'b0, '0);
    chk("stream_final_cmd", {12'h0, cmd}, 64'h3F);

    // Burst of 3 with ready 1,0,1,0,1.
    run_cmd(1'b1, 3, 3, 1, 1'b0, '0);

    // All-ones seed is rejected and flagged; a valid seed clears the flag.
    seed_load = 1'b1; seed_in = '1;
    tick();
    seed_load = 1'b0;
    chk("lockup_set", {63'h0, lockup}, 64'h1);
    chk("lockup_cmd", {12'h0, cmd}, {12'h0, SEED_V});
    model = SEED_V;
    seed_load = 1'b1; seed_in = W'(5);
    tick();
    seed_load = 1'b0;
    chk("lockup_clear", {63'h0, lockup}, 64'h0);
    chk("seed5_cmd", {12'h0, cmd}, 64'h5);
    model = W'(5);
    run_cmd(1'b0, 0, 3, 0, 1'b0, '0);

    // Zero-length burst: done pulse only.
    mode = 1'b1; burst_len = '0; start = 1'b1;
    tick();
    start = 1'b0; mode = 1'b0;
    $display("zero burst busy=%0d done=%0d count=%0d", busy, done, cmd_count);
    chk("zero_busy", {63'h0, busy}, 64'h0);
    chk("zero_done", {63'h0, done}, 64'h1);
    chk("zero_valid", {63'h0, cmd_valid}, 64'h0);
    chk("zero_count", {32'h0, cmd_count}, 64'h0);
    tick();
    chk("zero_done_clear", {63'h0, done}, 64'h0);
    chk("zero_valid_later", {63'h0, cmd_valid}, 64'h0);

    // Stream stopped with a handshake, then seed_load and start together.
    run_cmd(1'b0, 0, 4, 0, 1'b0, '0);
    sv = W'({$urandom, $urandom});
    if (sv == '1) sv[0] = 1'b0;
    run_cmd(1'b0, 0, 3, 0, 1'b1, sv);

    // Burst stopped early: no done pulse.
    run_cmd(1'b1, 8, 3, 0, 1'b0, '0);

    for (int k = 0; k < 12; k++) begin
      m   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 12);
      n   = (m && ($urandom_range(0, 3) != 0)) ? len : $urandom_range(1, len);
      sv  = W'({$urandom, $urandom});
      if (sv == '1) sv[0] = 1'b0;
      run_cmd(m, len, n, 0, ($urandom_range(0, 3) == 0), sv);
    end

    // Reset in the middle of a 10-word burst after two accepts.
    exp_q.push_back('{model, 0});
    exp_q.push_back('{model_next(model), 1});
    mode = 1'b1; burst_len = BW'(10); start = 1'b1;
    tick();
    start = 1'b0; mode = 1'b0;
    cmd_ready = 1'b1;
    tick();
    tick();
    cmd_ready = 1'b0;
    chk("midburst_count", {32'h0, cmd_count}, 64'h2);
    #1;
    rst = 1'b1;
    exp_q.delete();
    #1;
    $display("async reset cmd=0x%0h valid=%0d count=%0d done=%0d", cmd, cmd_valid, cmd_count, done);
    chk("arst_cmd", {12'h0, cmd}, {12'h0, SEED_V});
    chk("arst_valid", {63'h0, cmd_valid}, 64'h0);
    chk("arst_count", {32'h0, cmd_count}, 64'h0);
    chk("arst_done", {63'h0, done}, 64'h0);
    chk("arst_busy", {63'h0, busy}, 64'h0);
    tick();
    rst = 1'b0;
    model = SEED_V;
    tick();
    chk("arst_done_later", {63'h0, done}, 64'h0);
    run_cmd(1'b0, 0, 3, 2, 1'b0, '0);
    chk("post_reset_cmd", {12'h0, cmd}, 64'hF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
